// File: rtl/pix_xmit.sv
// Pixel burst transmitter: a circular FIFO feeds a request/echo handshake.
// Returned pixels are checked against the sent value XOR SCRAMBLE.
module pix_xmit #(
   parameter int         DEPTH    = 8,
   parameter int         TIMEOUT  = 15,
   parameter logic [7:0] SCRAMBLE = 8'b11001100
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       start,
   input  logic [3:0] burst_len,
   output logic       pix_req,
   output logic [7:0] pixel_out,
   input  logic       pixel_valid,
   input  logic [7:0] pixel_echo,
   output logic [3:0] count,
   output logic       full,
   output logic       busy,
   output logic       done,
   output logic       timeout,
   output logic       ovf,
   output logic [3:0] err_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_ERR} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [3:0]      r_count;
   logic [3:0]      r_remaining;
   logic [3:0]      r_err_cnt;
   logic [TW-1:0]   r_timer;
   logic [7:0]      r_pixel_out;
   logic            r_ovf;

   logic            w_accept;
   logic            w_pix_done;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic            w_ovf_set;
   logic            w_mismatch;
   logic [TW-1:0]   w_timer_inc;

   assign w_timer_inc = r_timer + TW'(1);
   assign w_full      = (r_count == 4'(DEPTH));
   assign w_pop       = (r_state == ST_REQ) && (r_count != 4'd0);
   assign w_flush     = (r_state == ST_ERR);
   // A pop in the same cycle frees a slot, so a push while full still lands.
   assign w_push      = wr_en && (!w_full || w_pop) && !w_flush;
   assign w_ovf_set   = wr_en && w_full && !w_pop;
   assign w_mismatch  = (pixel_echo != (r_pixel_out ^ SCRAMBLE));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_pix_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && (burst_len != 4'd0) && (r_count >= burst_len)) begin
               w_accept     = 1'b1;
               w_state_next = ST_REQ;
            end
         end
         ST_REQ:  w_state_next = ST_WAIT;
         ST_WAIT: begin
            // A late acknowledge wins over the timer expiring in the same cycle.
            if (pixel_valid) begin
               w_pix_done   = 1'b1;
               w_state_next = (r_remaining == 4'd1) ? ST_DONE : ST_REQ;
            end else if (w_timer_inc == TW'(TIMEOUT)) begin
               w_state_next = ST_ERR;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         ST_ERR:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 4'd0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 4'd0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + 4'd1;
         else if (w_pop && !w_push) r_count <= r_count - 4'd1;
      end
   end

   // Head is captured on entry to REQ so it shows alongside pix_req.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                       r_pixel_out <= 8'd0;
      else if (w_state_next == ST_REQ) r_pixel_out <= r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_remaining <= 4'd0;
         r_err_cnt   <= 4'd0;
         r_timer     <= '0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_remaining <= burst_len;
            r_err_cnt   <= 4'd0;
         end else if (w_pix_done) begin
            r_remaining <= r_remaining - 4'd1;
            if (w_mismatch && (r_err_cnt != 4'd15)) r_err_cnt <= r_err_cnt + 4'd1;
         end
         if (r_state == ST_REQ)                     r_timer <= '0;
         else if (r_state == ST_WAIT && !pixel_valid) r_timer <= w_timer_inc;
         if (w_ovf_set)     r_ovf <= 1'b1;
         else if (w_accept) r_ovf <= 1'b0;
      end
   end

   assign pix_req   = (r_state == ST_REQ);
   assign pixel_out = r_pixel_out;
   assign count     = r_count;
   assign full      = w_full;
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign timeout   = (r_state == ST_ERR);
   assign ovf       = r_ovf;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pix_xmit.sv
// Directed bench for pix_xmit: a per-cycle vector table for FIFO/overflow
// behaviour plus hand sequences for bursts, timeout and reset.
module tb_pix_xmit;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       start = 1'b0;
   logic [3:0] burst_len = 4'd0;
   logic       pixel_valid = 1'b0;
   logic [7:0] pixel_echo = 8'd0;
   logic       pix_req;
   logic [7:0] pixel_out;
   logic [3:0] count;
   logic       full, busy, done, timeout, ovf;
   logic [3:0] err_cnt;

   int checks = 0;
   int errors = 0;

   pix_xmit dut (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
      .start(start), .burst_len(burst_len), .pix_req(pix_req),
      .pixel_out(pixel_out), .pixel_valid(pixel_valid), .pixel_echo(pixel_echo),
      .count(count), .full(full), .busy(busy), .done(done),
      .timeout(timeout), .ovf(ovf), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       st;
      logic [3:0] bl;
      logic       pv;
      logic [7:0] echo;
      int         e_count;
      logic       e_full;
      logic       e_ovf;
      logic       e_busy;
      logic       e_req;
      logic       e_done;
      logic [7:0] e_pix;
   } vec_t;

   vec_t vt[15];

   function automatic vec_t mk(logic wr, logic [7:0] d, logic st, logic [3:0] bl,
                               logic pv, logic [7:0] ec, int cnt, logic fl, logic ov,
                               logic bz, logic rq, logic dn, logic [7:0] px);
      vec_t v;
      v.wr = wr; v.data = d; v.st = st; v.bl = bl; v.pv = pv; v.echo = ec;
      v.e_count = cnt; v.e_full = fl; v.e_ovf = ov; v.e_busy = bz;
      v.e_req = rq; v.e_done = dn; v.e_pix = px;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1;
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic do_reset;
      rstn = 1'b0;
      wr_en = 1'b0; start = 1'b0; pixel_valid = 1'b0; burst_len = 4'd0;
      step();
      step();
      rstn = 1'b1;
      step();
   endtask

   task automatic burst3(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input int exp_err);
      logic [7:0] px [3];
      logic [7:0] ec [3];
      px[0] = 8'h12; px[1] = 8'h34; px[2] = 8'h56;
      ec[0] = e0;    ec[1] = e1;    ec[2] = e2;
      do_reset();
      for (int i = 0; i < 3; i++) push(px[i]);
      start = 1'b1;
      burst_len = 4'd3;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_req"}, int'(pix_req), 1);
         chk({tag, "_pix"}, int'(pixel_out), int'(px[k]));
         step();
         chk({tag, "_wait_req"}, int'(pix_req), 0);
         chk({tag, "_wait_done"}, int'(done), 0);
         pixel_valid = 1'b1;
         pixel_echo = ec[k];
         step();
         pixel_valid = 1'b0;
      end
      // Seventh cycle after the start edge.
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_err"}, int'(err_cnt), exp_err);
      chk({tag, "_count"}, int'(count), 0);
      step();
      chk({tag, "_done_clr"}, int'(done), 0);
      chk({tag, "_idle"}, int'(busy), 0);
      chk({tag, "_err_hold"}, int'(err_cnt), exp_err);
      $display("burst %s err_cnt=%0d", tag, err_cnt);
   endtask

   initial begin
      int   waits;
      int   pulses;
      logic seen;

      for (int i = 0; i < 8; i++)
         vt[i] = mk(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 4'd0, 1'b0, 8'h00,
                    i + 1, (i == 7), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      vt[8]  = mk(1'b1, 8'h99, 1'b0, 4'd0, 1'b0, 8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      vt[9]  = mk(1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
      vt[10] = mk(1'b1, 8'hAA, 1'b0, 4'd0, 1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
      vt[11] = mk(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'hDD, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
      vt[12] = mk(1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
      vt[13] = mk(1'b0, 8'h00, 1'b1, 4'd9, 1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
      vt[14] = mk(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);

      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_req", int'(pix_req), 0);
      chk("rst_pix", int'(pixel_out), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_err", int'(err_cnt), 0);
      do_reset();

      for (int i = 0; i < 15; i++) begin
         wr_en = vt[i].wr; wr_data = vt[i].data; start = vt[i].st;
         burst_len = vt[i].bl; pixel_valid = vt[i].pv; pixel_echo = vt[i].echo;
         step();
         $display("vec %0d count=%0d full=%0b ovf=%0b busy=%0b req=%0b done=%0b pix=%02h",
                  i, count, full, ovf, busy, pix_req, done, pixel_out);
         chk($sformatf("vec%0d_count", i), int'(count), vt[i].e_count);
         chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].e_full));
         chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vt[i].e_ovf));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].e_busy));
         chk($sformatf("vec%0d_req", i), int'(pix_req), int'(vt[i].e_req));
         chk($sformatf("vec%0d_done", i), int'(done), int'(vt[i].e_done));
         chk($sformatf("vec%0d_pix", i), int'(pixel_out), int'(vt[i].e_pix));
      end
      wr_en = 1'b0; start = 1'b0; pixel_valid = 1'b0;

      burst3("good", 8'hDE, 8'hF8, 8'h9A, 0);
      burst3("mism", 8'hDE, 8'h00, 8'h9A, 1);

      // Rejected starts leave everything idle.
      do_reset();
      push(8'h01);
      push(8'h02);
      start = 1'b1; burst_len = 4'd3;
      step();
      start = 1'b0;
      chk("rej3_busy", int'(busy), 0);
      chk("rej3_req", int'(pix_req), 0);
      chk("rej3_count", int'(count), 2);
      start = 1'b1; burst_len = 4'd0;
      step();
      start = 1'b0;
      step();
      chk("rej0_busy", int'(busy), 0);
      chk("rej0_req", int'(pix_req), 0);
      chk("rej0_count", int'(count), 2);
      $display("reject count=%0d busy=%0b", count, busy);

      // Timeout with a push landing on the flush cycle.
      do_reset();
      push(8'hA1);
      push(8'hA2);
      start = 1'b1; burst_len = 4'd2;
      step();
      start = 1'b0;
      chk("to_req", int'(pix_req), 1);
      waits = 0; pulses = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         step();
         if (timeout) seen = 1'b1;
         else begin
            waits++;
            if (pix_req) pulses++;
         end
      end
      chk("to_seen", int'(seen), 1);
      chk("to_waits", waits, 15);
      chk("to_extra_req", pulses, 0);
      wr_en = 1'b1; wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      chk("to_count", int'(count), 0);
      chk("to_busy", int'(busy), 0);
      chk("to_pulse_clr", int'(timeout), 0);
      $display("timeout waits=%0d count=%0d", waits, count);

      // Acknowledge on the last WAIT cycle before expiry still completes.
      do_reset();
      push(8'h5A);
      start = 1'b1; burst_len = 4'd1;
      step();
      start = 1'b0;
      for (int w = 0; w < 15; w++) step();
      chk("edge_busy", int'(busy), 1);
      chk("edge_no_to", int'(timeout), 0);
      pixel_valid = 1'b1; pixel_echo = 8'h96;
      step();
      pixel_valid = 1'b0;
      chk("edge_done", int'(done), 1);
      chk("edge_to", int'(timeout), 0);
      chk("edge_err", int'(err_cnt), 0);
      $display("late-ack done=%0b timeout=%0b", done, timeout);

      // Reset during WAIT, after one mismatched pixel.
      do_reset();
      push(8'h10);
      push(8'h20);
      push(8'h30);
      start = 1'b1; burst_len = 4'd2;
      step();
      start = 1'b0;
      step();
      pixel_valid = 1'b1; pixel_echo = 8'h00;
      step();
      pixel_valid = 1'b0;
      step();
      chk("mid_pre_err", int'(err_cnt), 1);
      chk("mid_pre_count", int'(count), 1);
      chk("mid_pre_busy", int'(busy), 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_req", int'(pix_req), 0);
      chk("mid_busy", int'(busy), 0);
      chk("mid_count", int'(count), 0);
      chk("mid_err", int'(err_cnt), 0);
      chk("mid_pix", int'(pixel_out), 0);
      step();
      rstn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("mid_no_done", int'(done), 0);
         chk("mid_no_to", int'(timeout), 0);
      end
      $display("reset mid-burst busy=%0b count=%0d", busy, count);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pix_xmit.md
PIX_XMIT -- requirements
Module: pix_xmit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of 8-bit pixel FIFO entries.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles without pixel_valid before abort.
REQ-003 The block SHALL have parameter SCRAMBLE, default 8'b11001100, meaning the XOR pattern the far end applies to each pixel.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  push wr_data into the FIFO.
REQ-007 wr_data  input  8  pixel to queue.
REQ-008 start  input  1  one-cycle pulse that launches a burst.
REQ-009 burst_len  input  4  number of pixels in the burst, sampled at accepted start.
REQ-010 pix_req  output  1  pixel request strobe to the far end.
REQ-011 pixel_out  output  8  pixel presented to the far end; valid while pix_req=1, held afterwards.
REQ-012 pixel_valid  input  1  far-end acknowledge, qualifying pixel_echo.
REQ-013 pixel_echo  input  8  far-end returned pixel, expected equal to the sent pixel XOR SCRAMBLE.
REQ-014 count  output  4  FIFO occupancy, 0..DEPTH.
REQ-015 full  output  1  count==DEPTH.
REQ-016 busy  output  1  1 in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at burst completion.
REQ-018 timeout  output  1  one-cycle pulse at burst abort.
REQ-019 ovf  output  1  sticky flag: a push was attempted while full.
REQ-020 err_cnt  output  4  number of echo mismatches in the current or last burst; saturates at 15.

Function
REQ-021 The FIFO SHALL be circular, using wrapping read/write pointers; wr_en with full=0 SHALL push.
REQ-022 wr_en with full=1 SHALL NOT modify the FIFO and SHALL set ovf.
REQ-023 ovf SHALL be cleared only by reset or an accepted start.
REQ-024 A push and a pop in the same cycle SHALL both occur, leaving count unchanged; this includes the case full=1, where the push is accepted.
REQ-025 The FSM SHALL have states IDLE, REQ, WAIT, DONE and ERR.
REQ-026 In IDLE, start=1 with burst_len!=0 and count>=burst_len SHALL be accepted: latch remaining=burst_len, clear err_cnt, clear ovf, go to REQ.
REQ-027 In IDLE, any other start SHALL be ignored with no output change.
REQ-028 In all states other than IDLE, start SHALL be ignored.
REQ-029 REQ SHALL be exactly one cycle with these actions:
  - pix_req=1;
  - pixel_out = FIFO head, registered, so it is visible in the same cycle as pix_req;
  - pop the FIFO head;
  - clear the WAIT timer;
  - go to WAIT.
REQ-030 In WAIT, pix_req SHALL be 0.
REQ-031 In WAIT, pixel_valid=1 SHALL complete the pixel:
  - compare pixel_echo against pixel_out XOR SCRAMBLE;
  - on mismatch, increment err_cnt, saturating at 15;
  - decrement remaining;
  - if remaining was 1, go to DONE; otherwise go to REQ.
  A pixel therefore takes a minimum of 2 cycles.
REQ-032 In WAIT without pixel_valid, the timer SHALL increment; when it reaches TIMEOUT, the FSM SHALL go to ERR.
REQ-033 pixel_valid arriving in the same cycle the timer reaches TIMEOUT SHALL be treated as valid, not as a timeout.
REQ-034 pixel_valid SHALL be ignored outside WAIT.
REQ-035 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-036 ERR SHALL assert timeout for one cycle, flush the FIFO (count=0, pointers equal), then return to IDLE.
REQ-037 A push coincident with the ERR flush SHALL be discarded.
REQ-038 err_cnt SHALL hold its value after DONE or ERR until the next accepted start.

Reset
REQ-039 rstn=0 SHALL immediately force the FSM to IDLE at any point, including mid-burst.
REQ-040 rstn=0 SHALL immediately empty the FIFO.
REQ-041 rstn=0 SHALL immediately set pix_req, pixel_out, done, timeout, ovf, err_cnt, count and busy to 0, and set full to 0.
REQ-042 No pulse (done or timeout) SHALL be emitted as a result of reset release.

Verification
REQ-043 Directed scenario, correct burst:
  - push 8'h12, 8'h34, 8'h56; start with burst_len=3;
  - far end answers pixel_valid one cycle after each pix_req, with echoes 8'hDE, 8'hF8, 8'h9A;
  - required: three pix_req pulses carrying 8'h12, 8'h34, 8'h56; done pulses on cycle 7 after start; err_cnt=0; count=0.
REQ-044 Directed scenario, echo mismatch:
  - as REQ-043, but the second echo is 8'h00;
  - required: done pulses; err_cnt=1.
REQ-045 Directed scenario, timeout:
  - push 2 pixels; start with burst_len=2; never assert pixel_valid;
  - required: a single pix_req; timeout pulses 15 WAIT cycles later; count=0; busy=0.
REQ-046 Directed scenario, rejected start:
  - push 2 pixels; start with burst_len=3, then start with burst_len=0;
  - required: busy stays 0; pix_req stays 0; count=2.
REQ-047 Directed scenario, overflow and simultaneous push/pop:
  - push 9 pixels, then start with burst_len=1 and push in the REQ cycle;
  - required: ovf=1 after the 9th push; ovf=0 after start; count stays 8 across the REQ cycle.
REQ-048 Directed scenario, reset mid-burst:
  - assert rstn=0 during WAIT;
  - required: pix_req, busy, count and err_cnt go to 0 immediately, with no done or timeout pulse.
